pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It drives the write-enable and flush of the PC register, the IF/ID register and the ID/EX register. It resolves three hazard classes:
- load-use data hazards (one-bubble stall)
- taken branch/jump redirects from EX (multi-cycle fetch flush)
- data-memory wait (whole-pipeline freeze)

It also keeps optional performance counters.

Parameters:
- FLUSH_CYCLES, 1, number of consecutive cycles IF/ID is flushed after a redirect (covers fetch latency); legal range 1..15.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  input  1  pipeline clock; all state updates on posedge.
- rst  input  1  reset; synchronous and active-low (0 = reset).
- ID_rs1  input  5  rs1 index of the instruction in ID.
- ID_rs2  input  5  rs2 index of the instruction in ID.
- ID_use_rs1  input  1  the ID instruction reads rs1.
- ID_use_rs2  input  1  the ID instruction reads rs2.
- EX_MemRead  input  1  the EX instruction is a load.
- EX_rd  input  5  destination register of the EX instruction.
- EX_redirect  input  1  the EX branch/jump is taken (level; held by EX while frozen).
- mem_busy  input  1  data memory not ready; pipeline must freeze.
- PC_Write  output  1  PC register load enable.
- IF_ID_Write  output  1  IF/ID register load enable.
- IF_ID_Flush  output  1  IF/ID loads a NOP (0x00000013) and PC 0; has priority over IF_ID_Write inside the register.
- ID_EX_Flush  output  1  ID/EX loads a bubble (all control signals 0).
- EX_MEM_Write  output  1  EX/MEM and later register load enable.
- flush_active  output  1  state == FLUSH (debug).
- stall_cnt  output  CNT_W  cycles spent in load-use stall.
- flush_cnt  output  CNT_W  cycles with IF_ID_Flush = 1.
- freeze_cnt  output  CNT_W  cycles frozen by mem_busy.

Behaviour:
- Reset
  - While rst = 0: state = RUN, flush_left = 0, all counters = 0.
  - All outputs are 0 (PC_Write, IF_ID_Write, EX_MEM_Write, both flushes, flush_active).
  - The first clock edge with rst = 1 resumes normal operation.
  - Reset asserted in FLUSH or during a freeze aborts the operation immediately; no pending state survives.
- Hazard term: load_use = EX_MemRead & (EX_rd != 0) & ((ID_use_rs1 & ID_rs1 == EX_rd) | (ID_use_rs2 & ID_rs2 == EX_rd)).
- Outputs are combinational from the current state and inputs, with zero latency. The state register is the only sequential decision element.
- State RUN, priority order (highest first):
  1. mem_busy = 1 (freeze): all enables 0, all flushes 0; state, flush_left and the redirect are held.
  2. EX_redirect = 1:
     - Outputs: PC_Write = 1, IF_ID_Write = 1, IF_ID_Flush = 1, ID_EX_Flush = 1, EX_MEM_Write = 1.
     - If FLUSH_CYCLES > 1: next state FLUSH with flush_left = FLUSH_CYCLES - 1. Otherwise stay in RUN.
     - The redirect wins over load_use in the same cycle; the load-use victim is younger and is flushed.
  3. load_use = 1:
     - Outputs: PC_Write = 0, IF_ID_Write = 0, ID_EX_Flush = 1, EX_MEM_Write = 1.
     - Stay in RUN. Exactly one bubble per load, because the load leaves EX next cycle.
  4. Otherwise: PC_Write = IF_ID_Write = EX_MEM_Write = 1, both flushes 0.
- State FLUSH:
  - Outputs: PC_Write = 1, IF_ID_Write = 1, IF_ID_Flush = 1, ID_EX_Flush = 0, EX_MEM_Write = 1. load_use is ignored because ID holds a NOP.
  - flush_left decrements each cycle; when flush_left == 1, next state is RUN.
  - mem_busy = 1 overrides (freeze) and holds flush_left.
  - EX_redirect = 1 in FLUSH reloads flush_left = FLUSH_CYCLES - 1 and applies the RUN redirect outputs.
- Counters: increment by 1 per qualifying cycle and saturate at all-ones (no wrap).
  - stall_cnt: cycles where the load-use stall is applied.
  - flush_cnt: cycles with IF_ID_Flush = 1.
  - freeze_cnt: cycles with mem_busy = 1 while out of reset.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- Defined: the three counters are implemented as specified.
- Undefined: no counter flops are built; stall_cnt, flush_cnt and freeze_cnt are tied to 0. All other behaviour is identical.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - the state enum (RUN, FLUSH)
  - NOP_INST = 32'h00000013
  - REG_ZERO = 5'd0
- Natural sub-module: sat_counter (CNT_W, inc), instantiated three times under PIPE_HAZARD_PERF_EN.

Test Plan:
- Load-use: EX_MemRead = 1, EX_rd = 5, ID_rs1 = 5, ID_use_rs1 = 1, for 1 cycle -> PC_Write = 0, IF_ID_Write = 0, ID_EX_Flush = 1 that cycle; next cycle all enables 1; stall_cnt = 1.
- x0 filter: same as the load-use case but EX_rd = 0 and ID_rs1 = 0 -> no stall, PC_Write = 1.
- Redirect with FLUSH_CYCLES = 3: EX_redirect pulse -> IF_ID_Flush = 1 for 3 consecutive cycles, ID_EX_Flush = 1 only in the first; flush_active = 1 for cycles 2-3; flush_cnt = 3.
- Simultaneous redirect + load_use -> redirect outputs (ID_EX_Flush = 1, PC_Write = 1); stall_cnt unchanged.
- Freeze mid-FLUSH: mem_busy = 1 for 4 cycles at the 2nd flush cycle -> all enables and flushes 0 for 4 cycles, then the flush resumes with its remaining 2 cycles; freeze_cnt = 4.
- Reset mid-FLUSH: rst = 0 for 1 cycle -> all outputs 0; afterwards state RUN, counters 0, IF_ID_Flush = 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state type and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;
   typedef enum logic {RUN, FLUSH} state_t;
   localparam logic [31:0] NOP_INST = 32'h00000013;
   localparam logic [4:0]  REG_ZERO = 5'd0;
endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
module sat_counter
   import pipe_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);
   always_ff @(posedge clk)
      cnt <= !rst ? '0 : (inc && !(&cnt)) ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/freeze sequencer for the 5-stage pipeline.
// Performance counters are built only when PIPE_HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       ID_rs1,
   input  logic [4:0]       ID_rs2,
   input  logic             ID_use_rs1,
   input  logic             ID_use_rs2,
   input  logic             EX_MemRead,
   input  logic [4:0]       EX_rd,
   input  logic             EX_redirect,
   input  logic             mem_busy,
   output logic             PC_Write,
   output logic             IF_ID_Write,
   output logic             IF_ID_Flush,
   output logic             ID_EX_Flush,
   output logic             EX_MEM_Write,
   output logic             flush_active,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [CNT_W-1:0] freeze_cnt
);
   localparam logic [3:0] RELOAD = 4'(FLUSH_CYCLES - 1);

   state_t     state, state_n;
   logic [3:0] flush_left, left_n;
   logic       load_use, active, redir, stall;

   assign load_use = EX_MemRead && (EX_rd != REG_ZERO) &&
                     ((ID_use_rs1 && ID_rs1 == EX_rd) || (ID_use_rs2 && ID_rs2 == EX_rd));

   always_ff @(posedge clk) begin
      state      <= !rst ? RUN  : state_n;
      flush_left <= !rst ? 4'd0 : left_n;
   end

   // a freeze holds everything, including a pending redirect still sitting in EX
   always_comb begin
      state_n = state;
      left_n  = flush_left;
      if (!mem_busy && EX_redirect) begin
         state_n = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
         left_n  = RELOAD;
      end else if (!mem_busy && state == FLUSH) begin
         state_n = (flush_left == 4'd1) ? RUN : FLUSH;
         left_n  = flush_left - 4'd1;
      end
   end

   always_comb begin
      active       = rst && !mem_busy;
      redir        = active && EX_redirect;
      stall        = active && !EX_redirect && state == RUN && load_use;
      PC_Write     = active && !stall;
      IF_ID_Write  = active && !stall;
      IF_ID_Flush  = redir || (active && state == FLUSH);
      ID_EX_Flush  = redir || stall;
      EX_MEM_Write = active;
      flush_active = rst && state == FLUSH;
   end

`ifdef PIPE_HAZARD_PERF_EN
   sat_counter #(.CNT_W(CNT_W)) u_stall  (.clk(clk), .rst(rst), .inc(stall),       .cnt(stall_cnt));
   sat_counter #(.CNT_W(CNT_W)) u_flush  (.clk(clk), .rst(rst), .inc(IF_ID_Flush), .cnt(flush_cnt));
   sat_counter #(.CNT_W(CNT_W)) u_freeze (.clk(clk), .rst(rst), .inc(mem_busy),    .cnt(freeze_cnt));
`else
   assign stall_cnt  = '0;
   assign flush_cnt  = '0;
   assign freeze_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and randomized checks of pipe_hazard_ctrl against a cycle model.
module tb_pipe_hazard_ctrl;
   localparam int FC   = 3;
   localparam int CW   = 6;
   localparam int MAXC = (1 << CW) - 1;
`ifdef PIPE_HAZARD_PERF_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [4:0]    ID_rs1, ID_rs2, EX_rd;
   logic          ID_use_rs1, ID_use_rs2, EX_MemRead, EX_redirect, mem_busy;
   logic          PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Write, flush_active;
   logic [CW-1:0] stall_cnt, flush_cnt, freeze_cnt;

   int checks = 0, failures = 0;
   int m_left = 0, m_stall = 0, m_flush = 0, m_freeze = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
      .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2), .EX_MemRead(EX_MemRead),
      .EX_rd(EX_rd), .EX_redirect(EX_redirect), .mem_busy(mem_busy),
      .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
      .ID_EX_Flush(ID_EX_Flush), .EX_MEM_Write(EX_MEM_Write), .flush_active(flush_active),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit lu_f();
      return EX_MemRead && EX_rd != 0 &&
             ((ID_use_rs1 && ID_rs1 == EX_rd) || (ID_use_rs2 && ID_rs2 == EX_rd));
   endfunction

   // expected {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Write, flush_active}
   function automatic logic [5:0] exp_out();
      logic fa;
      fa = m_left > 0;
      if (!rst)        return 6'b000000;
      if (mem_busy)    return {5'b00000, fa};
      if (EX_redirect) return {5'b11111, fa};
      if (fa)          return 6'b111011;
      if (lu_f())      return 6'b000110;
      return 6'b110010;
   endfunction

   function automatic int sat(input int v);
      return (v > MAXC) ? MAXC : v;
   endfunction

   task automatic model_edge();
      if (!rst) begin
         m_left = 0; m_stall = 0; m_flush = 0; m_freeze = 0;
      end else if (mem_busy) m_freeze = sat(m_freeze + 1);
      else if (EX_redirect) begin
         m_left  = FC - 1;
         m_flush = sat(m_flush + 1);
      end else if (m_left > 0) begin
         m_left--;
         m_flush = sat(m_flush + 1);
      end else if (lu_f()) m_stall = sat(m_stall + 1);
   endtask

   task automatic cyc(input string tag);
      #1;
      chk({tag, ":outs"}, {26'b0, PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Write, flush_active},
          {26'b0, exp_out()});
      chk({tag, ":stall_cnt"},  {26'b0, stall_cnt},  32'(P * m_stall));
      chk({tag, ":flush_cnt"},  {26'b0, flush_cnt},  32'(P * m_flush));
      chk({tag, ":freeze_cnt"}, {26'b0, freeze_cnt}, 32'(P * m_freeze));
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic idle();
      rst = 1'b1; ID_rs1 = 5'd1; ID_rs2 = 5'd2; ID_use_rs1 = 1'b0; ID_use_rs2 = 1'b0;
      EX_MemRead = 1'b0; EX_rd = 5'd3; EX_redirect = 1'b0; mem_busy = 1'b0;
   endtask

   initial begin
      idle();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      cyc("reset");
      // load-use on rs1
      idle(); EX_MemRead = 1'b1; EX_rd = 5'd5; ID_rs1 = 5'd5; ID_use_rs1 = 1'b1;
      #1;
      chk("lu_pc", PC_Write, 0); chk("lu_ifw", IF_ID_Write, 0); chk("lu_idf", ID_EX_Flush, 1);
      cyc("lu");
      idle(); cyc("lu_next");
      chk("lu_cnt", stall_cnt, P);
      // x0 never creates a hazard
      idle(); EX_MemRead = 1'b1; EX_rd = 5'd0; ID_rs1 = 5'd0; ID_use_rs1 = 1'b1;
      #1; chk("x0_pc", PC_Write, 1);
      cyc("x0");
      // redirect pulse: three flush cycles
      idle(); rst = 1'b0; cyc("rst_a");
      idle(); EX_redirect = 1'b1;
      #1; chk("rd_idf", ID_EX_Flush, 1); chk("rd_fa", flush_active, 0);
      cyc("rd0");
      idle();
      #1; chk("rd1_fa", flush_active, 1); chk("rd1_idf", ID_EX_Flush, 0);
      cyc("rd1"); cyc("rd2");
      #1; chk("rd3_iff", IF_ID_Flush, 0);
      cyc("rd3");
      chk("rd_cnt", flush_cnt, 3 * P);
      // redirect beats load-use
      idle(); EX_redirect = 1'b1; EX_MemRead = 1'b1; EX_rd = 5'd7; ID_rs2 = 5'd7; ID_use_rs2 = 1'b1;
      #1; chk("rl_idf", ID_EX_Flush, 1); chk("rl_pc", PC_Write, 1);
      cyc("rl");
      idle(); cyc("rl1"); cyc("rl2");
      chk("rl_stall", stall_cnt, 0);
      // freeze during the second flush cycle
      idle(); rst = 1'b0; cyc("rst_b");
      idle(); EX_redirect = 1'b1; cyc("fz0");
      idle(); mem_busy = 1'b1;
      repeat (4) begin
         #1; chk("fz_pc", PC_Write, 0); chk("fz_iff", IF_ID_Flush, 0);
         cyc("fz");
      end
      idle(); cyc("fz_r1"); cyc("fz_r2");
      #1; chk("fz_done", IF_ID_Flush, 0);
      cyc("fz_end");
      chk("fz_cnt", freeze_cnt, 4 * P); chk("fz_fcnt", flush_cnt, 3 * P);
      // reset in the middle of a flush
      idle(); EX_redirect = 1'b1; cyc("rf0");
      idle(); rst = 1'b0;
      #1; chk("rf_out", {IF_ID_Flush, PC_Write, flush_active}, 0);
      cyc("rf_rst");
      idle();
      #1; chk("rf_iff", IF_ID_Flush, 0); chk("rf_cnt", flush_cnt, 0);
      cyc("rf_after");
      // random traffic; long reset-free stretch drives counters into saturation
      for (int i = 0; i < 600; i++) begin
         rst         = (i < 300) || ($urandom_range(39) != 0);
         EX_redirect = $urandom_range(5) == 0;
         mem_busy    = $urandom_range(5) == 0;
         EX_MemRead  = 1'($urandom_range(1));
         EX_rd       = 5'($urandom_range(3));
         ID_rs1      = 5'($urandom_range(3));
         ID_rs2      = 5'($urandom_range(3));
         ID_use_rs1  = 1'($urandom_range(1));
         ID_use_rs2  = 1'($urandom_range(1));
         cyc("rand");
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
